// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, reads one word per PC over a req/ack
// handshake and hands pc4/ins to the IF/ID register under a write strobe.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        ifid_we,
    output logic        imem_err
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic {S_FETCH, S_READY} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_pc;
    logic [31:0]     r_ins;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_ack;
    logic            w_adv;
    logic            w_wait;
    logic [31:0]     w_pc4;
    logic [31:0]     w_sel;
    logic [31:0]     w_npc;

    assign w_pc4  = r_pc + 32'd4;
    assign w_ack  = (r_state == S_FETCH) && imem_ack;
    assign w_wait = (r_state == S_FETCH) && !imem_ack;
    assign w_adv  = (r_state == S_READY) && wpcir;

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (imem_ack) w_next = S_READY;
            S_READY: if (wpcir)    w_next = S_FETCH;
            default:               w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_sel = w_pc4;
        case (pcsource)
            2'b00:   w_sel = w_pc4;
            2'b01:   w_sel = bpc;
            2'b10:   w_sel = rpc;
            default: w_sel = jpc;
        endcase
    end

    // Targets are word-aligned; a misaligned jr register value is truncated.
    assign w_npc = {w_sel[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_pc  <= {RESET_PC[31:2], 2'b00};
            r_ins <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_ack) r_ins <= imem_rdata;
            if (w_adv) begin
                r_pc  <= w_npc;
                r_cnt <= '0;
            end
            // Counter saturates at the limit; the request is never dropped.
            if (w_wait) begin
                if (r_cnt != CW'(WAIT_LIMIT)) r_cnt <= r_cnt + CW'(1);
                if (r_cnt >= CW'(WAIT_LIMIT - 1)) r_err <= 1'b1;
            end
        end
    end

    assign imem_req  = clrn && (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign ins       = r_ins;
    assign ins_valid = (r_state == S_READY);
    assign ifid_we   = ins_valid & wpcir;
    assign imem_err  = r_err;

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: memory model acks requests and queues the expected
// pc4/ins pair, popped and compared whenever ifid_we pulses.
module tb_pipe_fetch;

    logic        clk = 1'b0;
    logic        clrn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, pc4, ins;
    logic        ins_valid, ifid_we, imem_err;

    logic        auto_ack;
    logic        force_ack;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;

    exp_t sb_q[$];

    pipe_fetch #(.RESET_PC(32'h0), .WAIT_LIMIT(4)) dut (
        .clk(clk), .clrn(clrn), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .pc4(pc4), .ins(ins), .ins_valid(ins_valid),
        .ifid_we(ifid_we), .imem_err(imem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h400) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Memory model and scoreboard; both act at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (ifid_we) begin
            if (sb_q.size() == 0) check("sb_extra_we", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                check("sb_pc4", pc4, e.pc4);
                check("sb_ins", ins, e.ins);
            end
        end
        if (auto_ack && imem_req) begin
            imem_ack   = 1'b1;
            imem_rdata = mem(imem_addr);
            e.pc4 = imem_addr + 32'd4;
            e.ins = mem(imem_addr);
            sb_q.push_back(e);
        end else begin
            imem_ack   = force_ack;
            imem_rdata = force_ack ? 32'hBAD0_BAD0 : 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; wpcir = 1'b1; pcsource = 2'b00;
        bpc = '0; rpc = '0; jpc = '0;
        auto_ack = 1'b0; force_ack = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;

        // Reset state
        to_pos(); to_pos();
        @(negedge clk);
        check("rst_req",   {31'b0, imem_req},  32'd0);
        check("rst_pc",    pc,                 32'h0);
        check("rst_vld",   {31'b0, ins_valid}, 32'd0);
        check("rst_ins",   ins,                32'h0);
        check("rst_err",   {31'b0, imem_err},  32'd0);

        // Sequential fetch with same-cycle ack
        to_pos();
        clrn = 1'b1; auto_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("seq_req",  {31'b0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(k * 4));
            @(negedge clk);
            check("seq_we",   {31'b0, ifid_we},  32'd1);
        end

        // Branch / jr / jump targets
        to_pos();
        to_pos();
        check("br_pc", pc, 32'h10);
        pcsource = 2'b01; bpc = 32'h100;
        to_pos();
        check("br_addr", imem_addr, 32'h100);
        to_pos();
        pcsource = 2'b10; rpc = 32'h203;
        to_pos();
        check("jr_addr", imem_addr, 32'h200);
        to_pos();
        pcsource = 2'b11; jpc = 32'h400;
        to_pos();
        check("j_addr", imem_addr, 32'h400);
        pcsource = 2'b00;
        to_pos();

        // Load-use stall in READY
        wpcir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_we",  {31'b0, ifid_we},  32'd0);
            check("stall_req", {31'b0, imem_req}, 32'd0);
            check("stall_pc",  pc,  32'h400);
            check("stall_pc4", pc4, 32'h404);
            check("stall_ins", ins, 32'hDEADBEEF);
            to_pos();
        end
        wpcir = 1'b1; auto_ack = 1'b0;

        // Timeout with ack withheld
        to_pos();
        for (int i = 1; i <= 4; i++) begin
            check("to_err_low", {31'b0, imem_err}, 32'd0);
            check("to_req",     {31'b0, imem_req}, 32'd1);
            to_pos();
        end
        check("to_err_set", {31'b0, imem_err}, 32'd1);
        to_pos(); to_pos();
        check("to_err_hold", {31'b0, imem_err}, 32'd1);
        check("to_req_hold", {31'b0, imem_req}, 32'd1);
        check("to_addr",     imem_addr, 32'h404);
        auto_ack = 1'b1;
        to_pos();
        check("late_vld", {31'b0, ins_valid}, 32'd1);
        check("late_ins", ins, mem(32'h404));
        check("late_err", {31'b0, imem_err}, 32'd1);
        auto_ack = 1'b0;

        // Reset colliding with an ack mid-fetch
        to_pos();
        check("mid_addr", imem_addr, 32'h408);
        clrn = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        check("rstack_req", {31'b0, imem_req}, 32'd0);
        to_pos();
        check("rstack_pc",  pc, 32'h0);
        check("rstack_vld", {31'b0, ins_valid}, 32'd0);
        check("rstack_ins", ins, 32'h0);
        check("rstack_err", {31'b0, imem_err}, 32'd0);
        check("rstack_req2", {31'b0, imem_req}, 32'd0);
        force_ack = 1'b0;

        // PC wrap at the top of the address space
        clrn = 1'b1; auto_ack = 1'b1;
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        to_pos();
        to_pos();
        check("wrap_pc",  pc,  32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        pcsource = 2'b00;
        to_pos();
        to_pos();
        check("wrap_addr", imem_addr, 32'h0);
        auto_ack = 1'b0;

        to_pos(); to_pos(); to_pos();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
